// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE} icache_state_t;

    function automatic int off_bits(input int line_words);
        return 2 + $clog2(line_words);
    endfunction

    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int line_words, input int num_lines);
        return 32 - off_bits(line_words) - idx_bits(num_lines);
    endfunction

endpackage

// File: rtl/icache_tagmem.sv
// Tag and valid storage: combinational read, single write port, flash clear of all valid bits.
module icache_tagmem
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_BITS  = 4,
    parameter int TAG_BITS  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_we,
    input  logic [IDX_BITS-1:0] i_widx,
    input  logic [TAG_BITS-1:0] i_wtag,
    input  logic                i_wvalid,
    input  logic [IDX_BITS-1:0] i_ridx,
    output logic [TAG_BITS-1:0] o_rtag,
    output logic                o_rvalid
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_BITS-1:0]  r_tag [NUM_LINES];

    // Clear has priority over a same-cycle write so an invalidate always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= i_wvalid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx] <= i_wtag;
        end
    end

    assign o_rtag   = r_tag[i_ridx];
    assign o_rvalid = r_valid[i_ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-line fill FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    input  logic        fetch_en,
    input  logic        invalidate,
    output logic [31:0] instrF,
    output logic        icache_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_BITS = off_bits(LINE_WORDS);
    localparam int IDX_BITS = idx_bits(NUM_LINES);
    localparam int TAG_BITS = tag_bits(LINE_WORDS, NUM_LINES);
    localparam int CNT_W    = OFF_BITS - 2;
    localparam int LINE_W   = 32 - OFF_BITS;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

    icache_state_t       r_state;
    logic [LINE_W-1:0]   r_miss_line;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_kill;
    logic                r_mem_req;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_data [NUM_LINES][LINE_WORDS];

    logic [LINE_W-1:0]   w_line;
    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0] w_tag;
    logic [CNT_W-1:0]    w_word;
    logic [TAG_BITS-1:0] w_rtag;
    logic                w_rvalid;
    logic                w_hit;
    logic [IDX_BITS-1:0] w_fill_idx;
    logic                w_unused;

    assign w_line     = pcF[31:OFF_BITS];
    assign w_idx      = w_line[IDX_BITS-1:0];
    assign w_tag      = w_line[LINE_W-1:IDX_BITS];
    assign w_word     = pcF[OFF_BITS-1:2];
    assign w_fill_idx = r_miss_line[IDX_BITS-1:0];
    assign w_unused   = ^{pcF[1:0], fetch_en};

    icache_tagmem #(
        .NUM_LINES (NUM_LINES),
        .IDX_BITS  (IDX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_tagmem (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (invalidate),
        .i_we     (r_state == DONE),
        .i_widx   (w_fill_idx),
        .i_wtag   (r_miss_line[LINE_W-1:IDX_BITS]),
        .i_wvalid (!r_kill),
        .i_ridx   (w_idx),
        .o_rtag   (w_rtag),
        .o_rvalid (w_rvalid)
    );

    assign w_hit        = w_rvalid && (w_rtag == w_tag) && (r_state == IDLE);
    assign instrF       = w_hit ? r_data[w_idx][w_word] : 32'h0;
    assign icache_stall = !w_hit;
    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;

    // mem_addr only advances after a completed word, keeping it stable per request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_miss_line <= '0;
            r_cnt       <= '0;
            r_kill      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_hit) begin
                        r_miss_line <= w_line;
                        r_cnt       <= '0;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= {w_line, {OFF_BITS{1'b0}}};
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (invalidate) begin
                        r_kill <= 1'b1;
                    end
                    if (mem_valid) begin
                        if (r_cnt == LAST_WORD) begin
                            r_mem_req <= 1'b0;
                            r_state   <= DONE;
                        end else begin
                            r_cnt      <= r_cnt + 1'b1;
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                DONE: begin
                    r_kill  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == REQ) && mem_valid) begin
            r_data[w_fill_idx][r_cnt] <= mem_rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (fetch_en && w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if ((r_state == IDLE) && !w_hit) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios then random accesses, checked against a line-level cache model.
module tb_icache;

    localparam int LW   = 4;
    localparam int NL   = 16;
    localparam int OFFB = 2 + $clog2(LW);
    localparam int IDXB = $clog2(NL);
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcF;
    logic        fetch_en;
    logic        invalidate;
    logic [31:0] instrF;
    logic        icache_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
        .clk          (clk),
        .reset        (reset),
        .pcF          (pcF),
        .fetch_en     (fetch_en),
        .invalidate   (invalidate),
        .instrF       (instrF),
        .icache_stall (icache_stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Backing memory: completes each request after lat cycles of mem_req.
    int lat  = 1;
    int wcnt = 0;
    assign mem_valid = mem_req && (wcnt == lat - 1);
    assign mem_rdata = mem_addr ^ KEY;

    always @(posedge clk or posedge reset) begin
        if (reset)                      wcnt <= 0;
        else if (mem_req && !mem_valid) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end

    // Reference model: per-index valid/tag, plus expected counters.
    bit          mvalid [NL];
    logic [31:0] mtag   [NL];
    int unsigned exp_hits   = 0;
    int unsigned exp_misses = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
    endtask

    task automatic chk_stats();
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
`endif
    endtask

    // One fetch at addr starting this cycle; on a miss runs through the whole fill.
    // inv_cyc: -1 none, 0 during the lookup cycle, k>=1 during fill cycle k.
    task automatic access(input logic [31:0] addr, input int n, input int inv_cyc,
                          input bit toggle, input int fe);
        int          idx;
        logic [31:0] tag;
        logic [31:0] base;
        bit          hit;
        int          s;
        int          done;
        idx  = int'((addr >> OFFB) % NL);
        tag  = addr >> (OFFB + IDXB);
        base = addr & ~(32'(LW * 4) - 32'd1);
        hit  = mvalid[idx] && (mtag[idx] == tag);
        lat  = n;
        pcF        = addr | 32'($urandom_range(0, 3));
        fetch_en   = (fe > 1) ? 1'($urandom_range(0, 1)) : 1'(fe);
        invalidate = (inv_cyc == 0);
        if (hit) begin
            @(negedge clk);
            chk("hit_stall", {31'b0, icache_stall}, 32'd0);
            chk("hit_instr", instrF, {addr[31:2], 2'b00} ^ KEY);
            chk("hit_noreq", {31'b0, mem_req}, 32'd0);
            if (fetch_en) exp_hits++;
            if (inv_cyc == 0) model_clear();
            @(posedge clk); #1;
            invalidate = 1'b0;
        end else begin
            s    = 2 + LW * n;
            done = 0;
            exp_misses++;
            for (int c = 0; c < s; c++) begin
                @(negedge clk);
                chk("miss_stall", {31'b0, icache_stall}, 32'd1);
                chk("miss_instr", instrF, 32'd0);
                chk("miss_req", {31'b0, mem_req}, {31'b0, (c >= 1) && (c <= s - 2)});
                if (mem_req) begin
                    chk("mem_addr", mem_addr, base + 32'(4 * done));
                    if (mem_valid) done++;
                end
                @(posedge clk); #1;
                invalidate = (inv_cyc == c + 1);
                if (toggle) pcF = (c + 1 <= s - 2) ? $urandom : addr;
            end
            invalidate = 1'b0;
            chk("fill_words", 32'(done), 32'(LW));
            if (inv_cyc >= 0) model_clear();
            mtag[idx]   = tag;
            mvalid[idx] = !(inv_cyc >= 1);
        end
        chk_stats();
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        int          inv;
        model_clear();
        reset      = 1'b1;
        pcF        = 32'h40;
        fetch_en   = 1'b0;
        invalidate = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_stall", {31'b0, icache_stall}, 32'd1);
        chk("rst_instr", instrF, 32'd0);
        chk_stats();
        @(posedge clk); #1;
        reset = 1'b0;

        // Cold miss, then hits within the line.
        access(32'h40, 1, -1, 0, 1);
        access(32'h40, 1, -1, 0, 1);
        access(32'h44, 1, -1, 0, 1);
        access(32'h4C, 1, -1, 0, 1);
`ifdef ICACHE_STATS_EN
        chk("stats_t12_miss", miss_count, 32'd1);
        chk("stats_t12_hit", hit_count, 32'd3);
`endif
        // Conflict on the same index.
        access(32'h440, 1, -1, 0, 2);
        access(32'h440, 1, -1, 0, 2);
        access(32'h40, 1, -1, 0, 2);
        // Slow memory with pcF wandering during the fill.
        access(32'h88, 3, -1, 1, 2);
        access(32'h88, 3, -1, 0, 2);
        // Invalidate during word 2, then invalidate while idle.
        access(32'hC0, 1, 3, 0, 2);
        access(32'hC0, 1, -1, 0, 2);
        access(32'hC4, 1, -1, 0, 2);
        access(32'h40, 1, -1, 0, 2);
        access(32'h40, 1, 0, 0, 2);
        access(32'h40, 1, -1, 0, 2);
        access(32'hC8, 1, -1, 0, 2);
        // Invalidate coinciding with the line-complete cycle.
        access(32'h200, 1, 5, 0, 2);
        access(32'h200, 1, -1, 0, 2);

        // Asynchronous reset in the middle of a fill.
        lat = 2;
        pcF = 32'h100;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midfill_req", {31'b0, mem_req}, 32'd0);
        chk("midfill_addr", mem_addr, 32'd0);
        pcF = 32'h40;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_stats();
        access(32'h40, 1, -1, 0, 1);
        access(32'h40, 1, -1, 0, 1);

        for (int k = 0; k < 80; k++) begin
            a   = (32'($urandom_range(0, 3)) << (OFFB + IDXB)) |
                  (32'($urandom_range(0, 3)) << OFFB) |
                  (32'($urandom_range(0, LW - 1)) << 2);
            n   = $urandom_range(1, 3);
            inv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
            access(a, n, inv, 1'($urandom_range(0, 1)), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
